axis_sa_arb: RTL and testbench
==============================

# axis_sa_arb

Packet-level arbiter that shares one `axis_sa` systolic array among NS AXI-Stream requesters. It grants whole input packets (K beats of packed x/k data terminated by `last`) to one requester at a time, round-robin. It records the grantee ID in an in-order FIFO so the array's output packets are steered back to the right requester. It sits between the requester DMA/stream sources and the `axis_sa` instance.

## Interface
- NS, 2, number of requesters (≥2)
- R, 2, array rows
- C, 2, array columns
- WX, 4, x element width
- WK, 4, k element width
- WY, WX+WK+$clog2(K) (set by integrator), output element width
- DEPTH, 4, outstanding-packet ID FIFO depth (power of 2)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  NS  per-requester input valid
- s_ready  out  NS  per-requester input ready
- s_data  in  NS×(R*WX+C*WK)  per-requester beat, packed {k_col, x_row}
- s_last  in  NS  per-requester end of packet
- sa_s_valid / sa_s_ready / sa_s_last  out/in/out  1  to the array input
- sa_s_data  out  R*WX+C*WK  to the array input
- sa_m_valid / sa_m_ready / sa_m_last  in/out/in  1  from the array output
- sa_m_data  in  R*WY  from the array output
- m_valid  out  NS  per-requester output valid
- m_ready  in  NS  per-requester output ready
- m_data  out  R*WY  shared output bus (valid only for the asserted m_valid)
- m_last  out  1  shared output last

## Operation
- Input FSM states are IDLE and BUSY. It holds a grant register `sel` (clog2(NS) bits) and a round-robin pointer `rr`.
- IDLE:
  - Pick the first i with s_valid[i]=1, scanning rr, rr+1, … mod NS.
  - If one exists and the ID FIFO is not full: sel←i, push i into the FIFO, go to BUSY.
  - If the FIFO is full: stay in IDLE and grant nothing.
- BUSY:
  - Pass-through: sa_s_valid=s_valid[sel], sa_s_data=s_data[sel], sa_s_last=s_last[sel], s_ready[sel]=sa_s_ready.
  - All other s_ready are 0.
  - On handshake with sa_s_last=1: rr←sel+1 mod NS, go to IDLE.
- In IDLE: sa_s_valid=0 and all s_ready=0.
- Output steering uses head = FIFO front:
  - m_valid[head]=sa_m_valid & !empty; all other m_valid are 0.
  - sa_m_ready = !empty & m_ready[head].
  - m_data=sa_m_data, m_last=sa_m_last.
- On an output handshake with sa_m_last=1, pop the FIFO.
- If the FIFO is empty, sa_m_ready=0. Array output is stalled, never dropped.
- A requester that deasserts s_valid mid-packet keeps the grant. No timeout, no preemption.
- Push and pop in the same cycle are allowed, and the count is unchanged. The full check uses the pre-pop count, so a full FIFO blocks the grant even if a pop occurs that cycle.

## Timing
- Reset: state=IDLE, rr=0, sel=0, FIFO empty; all s_ready, m_valid, sa_s_valid, sa_m_ready = 0.
- Grant latency: 1 cycle. s_valid seen in IDLE at cycle t gives s_ready possible at t+1.
- There is exactly one idle bubble cycle between consecutive input packets.
- The data path is combinational with zero added latency in both directions. No registers sit on data.
- Asserting rst mid-packet aborts the packet: FIFO cleared, grant dropped. The array must be reset in the same cycle.

## Configuration
- With `AXIS_SA_ARB_PRIO_EN` defined: fixed priority, lowest index wins. rr is not updated and the scan always starts at 0.
- Without it: round-robin as described above.
- The FIFO and output steering are identical in both modes.

## Structure
- Package `axis_sa_pkg` holds:
  - the function computing WY from WX, WK, K;
  - the bus-width localparams WXK_BUS=R*WX+C*WK and WY_BUS=R*WY;
  - the `sel_t` typedef sized by NS.
- One sub-module, `id_fifo`: a synchronous FIFO with width clog2(NS), depth DEPTH, push/pop/full/empty/front.
- The arbiter FSM and steering live in the top.

## Test plan
- Single requester, NS=2, R=C=2, K=6: requester 0 sends a 6-beat packet.
  - s_ready[0] rises 1 cycle after s_valid.
  - The array receives 6 beats, last on beat 6.
  - The 2 output beats appear only on m_valid[0], with m_last on beat 2.
- Both requesters valid from reset:
  - Grants alternate 0,1,0,1 over 4 packets, with one bubble cycle between each.
  - Outputs return to 0,1,0,1 in order.
  - With `AXIS_SA_ARB_PRIO_EN`: all of requester 0's packets are granted before any of requester 1's.
- Hold all m_ready=0, DEPTH=4, both requesters streaming:
  - Exactly 4 packets are granted.
  - The FSM then stays in IDLE with s_ready=0.
  - Releasing m_ready[head] pops the FIFO and the 5th grant follows 1 cycle later.
- Requester 0 drops s_valid for 3 cycles mid-packet while requester 1 is valid:
  - s_ready[1] stays 0 and requester 0 completes its packet.
  - Requester 1 is granted next.
- m_ready[1]=0 while the FIFO head is 1:
  - sa_m_ready=0 and m_valid[0] stays 0, even though requester 0 has a packet queued behind.
- Assert rst during beat 3 of a packet:
  - The next cycle shows all outputs 0 and the FIFO empty.
  - After rst is released, a new packet from requester 1 is granted with rr=0 semantics.

Source files
------------

// File: rtl/axis_sa_pkg.sv
// Shared sizing for the axis_sa arbiter slice: array geometry, bus widths and grant ID type.
// The integrator edits the localparams here; every other file derives its widths from them.
package axis_sa_pkg;

   localparam int NS = 2;
   localparam int R  = 2;
   localparam int C  = 2;
   localparam int WX = 4;
   localparam int WK = 4;
   localparam int K  = 6;

   // Output element width grows by the accumulation depth of K products.
   function automatic int calc_wy(input int wx, input int wk, input int k);
      return wx + wk + $clog2(k);
   endfunction

   localparam int WY      = calc_wy(WX, WK, K);
   localparam int WXK_BUS = R * WX + C * WK;
   localparam int WY_BUS  = R * WY;
   localparam int SEL_W   = (NS > 1) ? $clog2(NS) : 1;

   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/axis_sa_arb_if.sv
// Bundle of requester-side, array-side and return-side AXI-Stream signals around axis_sa_arb.
// slave is the arbiter's view; master is the surrounding environment's view.
interface axis_sa_arb_if;
   import axis_sa_pkg::*;

   logic [NS-1:0]              s_valid;
   logic [NS-1:0]              s_ready;
   logic [NS-1:0][WXK_BUS-1:0] s_data;
   logic [NS-1:0]              s_last;

   logic                       sa_s_valid;
   logic                       sa_s_ready;
   logic [WXK_BUS-1:0]         sa_s_data;
   logic                       sa_s_last;

   logic                       sa_m_valid;
   logic                       sa_m_ready;
   logic [WY_BUS-1:0]          sa_m_data;
   logic                       sa_m_last;

   logic [NS-1:0]              m_valid;
   logic [NS-1:0]              m_ready;
   logic [WY_BUS-1:0]          m_data;
   logic                       m_last;

   modport slave (
      input  s_valid, s_data, s_last, sa_s_ready,
      input  sa_m_valid, sa_m_data, sa_m_last, m_ready,
      output s_ready, sa_s_valid, sa_s_data, sa_s_last,
      output sa_m_ready, m_valid, m_data, m_last
   );

   modport master (
      output s_valid, s_data, s_last, sa_s_ready,
      output sa_m_valid, sa_m_data, sa_m_last, m_ready,
      input  s_ready, sa_s_valid, sa_s_data, sa_s_last,
      input  sa_m_ready, m_valid, m_data, m_last
   );

endinterface

// File: rtl/id_fifo.sv
// In-order FIFO of grantee IDs, one entry per packet still owed an output packet.
// DEPTH must be a power of two, at least 2.
module id_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] front,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= din;
   end

   assign front = mem[rd_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/axis_sa_arb.sv
// Packet-level arbiter sharing one axis_sa array among NS requesters; outputs steered back in order.
// Define AXIS_SA_ARB_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axis_sa_arb
   import axis_sa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   axis_sa_arb_if.slave io
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state_q, state_d;
   sel_t   sel_q, sel_d;
   sel_t   scan_start;
   sel_t   pick;
   logic   found;
   sel_t   head;
   logic   fifo_full, fifo_empty;
   logic   push, pop;

`ifndef AXIS_SA_ARB_PRIO_EN
   sel_t   rr_q, rr_d;
`endif

   function automatic sel_t next_idx(input sel_t i);
      return (int'(i) == NS - 1) ? '0 : sel_t'(int'(i) + 1);
   endfunction

`ifdef AXIS_SA_ARB_PRIO_EN
   assign scan_start = '0;
`else
   assign scan_start = rr_q;
`endif

   // First valid requester at or after scan_start, wrapping modulo NS.
   always_comb begin
      sel_t idx;
      found = 1'b0;
      pick  = '0;
      idx   = scan_start;
      for (int k = 0; k < NS; k++) begin
         if (!found && io.s_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
         idx = next_idx(idx);
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      push    = 1'b0;
`ifndef AXIS_SA_ARB_PRIO_EN
      rr_d    = rr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (found && !fifo_full) begin
               sel_d   = pick;
               push    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (io.sa_s_valid && io.sa_s_ready && io.sa_s_last) begin
`ifndef AXIS_SA_ARB_PRIO_EN
               rr_d    = next_idx(sel_q);
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
`ifndef AXIS_SA_ARB_PRIO_EN
         rr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
`ifndef AXIS_SA_ARB_PRIO_EN
         rr_q    <= rr_d;
`endif
      end
   end

   // Input pass-through: only the grantee sees the array's ready.
   always_comb begin
      io.s_ready    = '0;
      io.sa_s_valid = 1'b0;
      io.sa_s_last  = 1'b0;
      io.sa_s_data  = io.s_data[sel_q];
      if (state_q == BUSY) begin
         io.sa_s_valid     = io.s_valid[sel_q];
         io.sa_s_last      = io.s_last[sel_q];
         io.s_ready[sel_q] = io.sa_s_ready;
      end
   end

   // Output steering follows the oldest outstanding grant; no owner means the array stalls.
   always_comb begin
      io.m_valid       = '0;
      io.m_valid[head] = io.sa_m_valid & ~fifo_empty;
      io.sa_m_ready    = ~fifo_empty & io.m_ready[head];
      io.m_data        = io.sa_m_data;
      io.m_last        = io.sa_m_last;
   end

   assign pop = io.sa_m_valid & io.sa_m_ready & io.sa_m_last;

   id_fifo #(
      .W     (SEL_W),
      .DEPTH (DEPTH)
   ) u_id_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (sel_d),
      .front (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_axis_sa_arb.sv
// Randomized bench for axis_sa_arb: requester drivers, a stand-in array and a packet-level grant model.
// Define AXIS_SA_ARB_PRIO_EN here too when building the fixed-priority variant.
module tb_axis_sa_arb;
   import axis_sa_pkg::*;

   localparam int DEPTH     = 4;
   localparam int OUT_BEATS = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axis_sa_arb_if bus ();

   axis_sa_arb #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Environment state
   int beat[NS], pkts_left[NS], pkt_seq[NS], acc[NS], rcv[NS];
   bit en[NS];
   int arr_q[$];
   int ob, arr_in_beats;
   int gnt_log[$], out_log[$];
   int p_sv, p_sr, p_mv, p_mr;
   bit rst_next, mv_force;

   // Reference model: current grantee (-1 = none), round-robin pointer, outstanding owner list
   int m_gnt, m_rr;
   int m_ids[$];

   function automatic bit roll(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   task automatic model_reset();
      m_gnt = -1;
      m_rr  = 0;
      m_ids.delete();
   endtask

   task automatic env_reset();
      for (int i = 0; i < NS; i++) begin
         beat[i] = 0;
         acc[i]  = rcv[i];
      end
      arr_q.delete();
      ob = 0;
      arr_in_beats = 0;
   endtask

   task automatic drive();
      rst = rst_next;
      for (int i = 0; i < NS; i++) begin
         bus.s_valid[i] = (((en[i] && pkts_left[i] > 0) || m_gnt == i) && roll(p_sv));
         bus.s_data[i]  = WXK_BUS'((i << 12) | ((pkt_seq[i] & 255) << 4) | beat[i]);
         bus.s_last[i]  = (beat[i] == K - 1);
         bus.m_ready[i] = roll(p_mr);
      end
      bus.sa_s_ready = roll(p_sr);
      bus.sa_m_valid = mv_force || (arr_q.size() > 0 && roll(p_mv));
      bus.sa_m_data  = WY_BUS'({$urandom, $urandom});
      bus.sa_m_last  = !mv_force && (ob == OUT_BEATS - 1);
   endtask

   task automatic check_and_update();
      logic [NS-1:0] e_sr, e_mv, e_own;
      logic          e_sv, e_mr;
      int            pre, start, idx;
      bit            do_pop, hit;

      // Expected outputs from the current inputs and the model's grant/owner state
      e_sr = '0; e_sv = 1'b0; e_mv = '0; e_mr = 1'b0;
      if (m_gnt >= 0) begin
         e_sr[m_gnt] = bus.sa_s_ready;
         e_sv        = bus.s_valid[m_gnt];
      end
      if (m_ids.size() > 0) begin
         e_mv[m_ids[0]] = bus.sa_m_valid;
         e_mr           = bus.m_ready[m_ids[0]];
      end
      check_eq("s_ready",    64'(bus.s_ready),    64'(e_sr));
      check_eq("sa_s_valid", 64'(bus.sa_s_valid), 64'(e_sv));
      if (m_gnt >= 0) begin
         check_eq("sa_s_data", 64'(bus.sa_s_data), 64'(bus.s_data[m_gnt]));
         check_eq("sa_s_last", 64'(bus.sa_s_last), 64'(bus.s_last[m_gnt]));
      end
      check_eq("m_valid",    64'(bus.m_valid),    64'(e_mv));
      check_eq("sa_m_ready", 64'(bus.sa_m_ready), 64'(e_mr));
      check_eq("m_data",     64'(bus.m_data),     64'(bus.sa_m_data));
      check_eq("m_last",     64'(bus.m_last),     64'(bus.sa_m_last));

      if (rst) begin
         model_reset();
         env_reset();
         return;
      end

      // Stand-in array output side: every beat must land on the owner of the oldest packet
      if (bus.sa_m_valid && bus.sa_m_ready) begin
         if (arr_q.size() == 0) begin
            check_eq("out_when_empty", 64'(bus.sa_m_ready), 64'(0));
         end else begin
            e_own = '0;
            e_own[arr_q[0]] = 1'b1;
            check_eq("steer", 64'(bus.m_valid), 64'(e_own));
            if (bus.sa_m_last) begin
               ob = 0;
               rcv[arr_q[0]]++;
               out_log.push_back(arr_q[0]);
               void'(arr_q.pop_front());
            end else begin
               ob++;
            end
         end
      end

      // Requester side and stand-in array input side
      for (int i = 0; i < NS; i++) begin
         if (bus.s_valid[i] && bus.s_ready[i]) begin
            if (beat[i] == 0) gnt_log.push_back(i);
            beat[i]++;
            arr_in_beats++;
            if (bus.s_last[i]) begin
               check_eq("pkt_len", 64'(arr_in_beats), 64'(K));
               arr_in_beats = 0;
               beat[i] = 0;
               pkt_seq[i]++;
               pkts_left[i]--;
               acc[i]++;
               arr_q.push_back(i);
            end
         end
      end

      // Model advance: grant rule in idle, release on last handshake, pop on last output beat
      pre    = m_ids.size();
      do_pop = (pre > 0) && bus.sa_m_valid && bus.m_ready[m_ids[0]] && bus.sa_m_last;
      if (m_gnt < 0) begin
`ifdef AXIS_SA_ARB_PRIO_EN
         start = 0;
`else
         start = m_rr;
`endif
         hit = 1'b0;
         for (int k = 0; k < NS; k++) begin
            idx = (start + k) % NS;
            if (!hit && bus.s_valid[idx]) begin
               hit = 1'b1;
               if (pre < DEPTH) begin
                  m_gnt = idx;
                  m_ids.push_back(idx);
               end
            end
         end
      end else if (bus.s_valid[m_gnt] && bus.sa_s_ready && bus.s_last[m_gnt]) begin
`ifndef AXIS_SA_ARB_PRIO_EN
         m_rr = (m_gnt + 1) % NS;
`endif
         m_gnt = -1;
      end
      if (do_pop) void'(m_ids.pop_front());
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check_and_update();
   endtask

   task automatic set_probs(input int sv, input int sr, input int mv, input int mr);
      p_sv = sv; p_sr = sr; p_mv = mv; p_mr = mr;
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int i = 0; i < NS; i++) en[i] = 1'b0;
      set_probs(100, 100, 100, 100);
      for (int c = 0; c < 600 && !done; c++) begin
         cycle();
         done = (m_gnt < 0) && (m_ids.size() == 0) && (arr_q.size() == 0);
      end
      check_eq(tag, 64'(done), 64'(1));
   endtask

   function automatic int q_at(input int q[$], input int k);
      return (k < q.size()) ? q[k] : -1;
   endfunction

   initial begin
      int exp_order[4];
      int base;
      bit hit;

      rst = 1'b1;
      bus.s_valid = '0; bus.s_last = '0; bus.m_ready = '0;
      for (int i = 0; i < NS; i++) begin
         bus.s_data[i] = '0;
         beat[i] = 0; pkts_left[i] = 0; pkt_seq[i] = 0; acc[i] = 0; rcv[i] = 0; en[i] = 1'b0;
      end
      bus.sa_s_ready = 1'b0; bus.sa_m_valid = 1'b0; bus.sa_m_data = '0; bus.sa_m_last = 1'b0;
      model_reset();
      env_reset();
      set_probs(100, 100, 100, 100);

      // Reset state, with array output and all m_ready pushed high
      rst_next = 1'b1;
      mv_force = 1'b1;
      repeat (3) cycle();
      check_eq("rst_s_ready",    64'(bus.s_ready),    64'(0));
      check_eq("rst_sa_s_valid", 64'(bus.sa_s_valid), 64'(0));
      check_eq("rst_m_valid",    64'(bus.m_valid),    64'(0));
      check_eq("rst_sa_m_ready", 64'(bus.sa_m_ready), 64'(0));
      mv_force = 1'b0;
      rst_next = 1'b0;

      // Both requesters streaming from reset
`ifdef AXIS_SA_ARB_PRIO_EN
      exp_order = '{0, 0, 1, 1};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      en[0] = 1'b1; en[1] = 1'b1;
      pkts_left[0] = 2; pkts_left[1] = 2;
      for (int c = 0; c < 400 && out_log.size() < 4; c++) cycle();
      for (int k = 0; k < 4; k++) begin
         check_eq("gnt_order", 64'(q_at(gnt_log, k)), 64'(exp_order[k]));
         check_eq("out_order", 64'(q_at(out_log, k)), 64'(exp_order[k]));
      end
      drain("drain_order");

      // Single requester, one packet
      base = out_log.size();
      en[0] = 1'b1; pkts_left[0] = 1;
      for (int c = 0; c < 100 && out_log.size() == base; c++) cycle();
      check_eq("single_owner", 64'(q_at(out_log, base)), 64'(0));
      drain("drain_single");

      // Returns blocked: grants stop once DEPTH packets are outstanding
      en[0] = 1'b1; en[1] = 1'b1;
      pkts_left[0] = 20; pkts_left[1] = 20;
      set_probs(100, 100, 100, 0);
      base = gnt_log.size();
      repeat (100) cycle();
      check_eq("stall_grants",  64'(gnt_log.size() - base), 64'(DEPTH));
      check_eq("stall_s_ready", 64'(bus.s_ready),           64'(0));
      check_eq("stall_sa_valid", 64'(bus.sa_s_valid),       64'(0));
      p_mr = 100;
      repeat (30) cycle();
      check_eq("stall_resume", 64'(gnt_log.size() - base > DEPTH), 64'(1));
      drain("drain_stall");

      // Randomized traffic, back-pressure, valid gaps and occasional resets
      en[0] = 1'b1; en[1] = 1'b1;
      pkts_left[0] = 1000; pkts_left[1] = 1000;
      for (int blk = 0; blk < 15; blk++) begin
         set_probs(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
                   int'($urandom_range(100, 20)), int'($urandom_range(100, 20)));
         for (int c = 0; c < 200; c++) begin
            rst_next = ($urandom_range(399, 0) == 0);
            cycle();
         end
      end
      rst_next = 1'b0;
      drain("drain_random");

      // Reset during beat 3 of a packet, then requester 1 alone
      en[0] = 1'b1; en[1] = 1'b1;
      set_probs(100, 100, 100, 100);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         cycle();
         hit = (m_gnt >= 0) && (beat[m_gnt] == 2);
      end
      check_eq("rst_mid_reached", 64'(hit), 64'(1));
      rst_next = 1'b1;
      cycle();
      rst_next = 1'b0;
      en[0] = 1'b0;
      mv_force = 1'b1;
      base = gnt_log.size();
      cycle();
      check_eq("rstmid_s_ready",    64'(bus.s_ready),    64'(0));
      check_eq("rstmid_sa_s_valid", 64'(bus.sa_s_valid), 64'(0));
      check_eq("rstmid_m_valid",    64'(bus.m_valid),    64'(0));
      check_eq("rstmid_sa_m_ready", 64'(bus.sa_m_ready), 64'(0));
      mv_force = 1'b0;
      repeat (5) cycle();
      check_eq("rstmid_regrant", 64'(q_at(gnt_log, base)), 64'(1));
      drain("drain_final");

      for (int i = 0; i < NS; i++) check_eq("accounting", 64'(rcv[i]), 64'(acc[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
